// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: handshake bundle for one pipeline stage boundary.
//   in_valid/in_ready/in_ctrl/in_data      upstream side
//   out_valid/out_ready/out_ctrl/out_data  downstream side
//   flush, hold_in                         hazard/branch control into the stage
//   occupancy                              number of beats held by the stage (0..2)
// Modports: slave = the stage itself, master = whatever surrounds it.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 56
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic              hold_in;
    logic [1:0]        occupancy;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready, flush, hold_in,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready, flush, hold_in,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with a two-entry skid buffer,
// synchronous flush and hazard hold.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pipe_stage_skid_if.slave (handshake, flush, hold_in, occupancy)
//
// state | meaning
// EMPTY | main and skid invalid, out_valid=0
// ONE   | main valid, skid invalid
// FULL  | main and skid valid, in_ready=0
module pipe_stage_skid #(
    parameter int CTRL_W    = 12,
    parameter int DATA_W    = 56,
    parameter bit ZERO_CTRL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_stage_skid_if.slave       bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic consume;

    // in_ready depends only on registered skid state and hold_in, so
    // downstream back-pressure never reaches upstream combinationally.
    assign bus.in_ready = ~skid_valid & ~bus.hold_in;
    assign accept       = bus.in_valid & bus.in_ready;
    assign consume      = main_valid & bus.out_ready;

    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = (ZERO_CTRL && !main_valid) ? '0 : main_ctrl;
    assign bus.occupancy = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (bus.flush) begin
            // Data registers deliberately keep their contents; only validity dies.
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl  <= bus.in_ctrl;
                        main_data  <= bus.in_data;
                        main_valid <= 1'b1;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_ctrl <= bus.in_ctrl;
                        main_data <= bus.in_data;
                    end else if (accept) begin
                        skid_ctrl  <= bus.in_ctrl;
                        skid_data  <= bus.in_data;
                        skid_valid <= 1'b1;
                        state      <= FULL;
                    end else if (consume) begin
                        main_valid <= 1'b0;
                        state      <= EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                        state      <= ONE;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    localparam int CW = 12;
    localparam int DW = 56;

    logic clk;
    logic rst;

    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ZERO_CTRL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int passed;

    typedef struct {
        logic          iv;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic          ordy;
        logic          fl;
        logic          hold;
        logic          e_rdy;
        logic          e_ov;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_data;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic iv, logic [CW-1:0] ctrl, logic [DW-1:0] data,
                                logic ordy, logic fl, logic hold, logic e_rdy,
                                logic e_ov, logic [CW-1:0] e_ctrl,
                                logic [DW-1:0] e_data, logic [1:0] e_occ);
        vec_t v;
        v.iv = iv; v.ctrl = ctrl; v.data = data; v.ordy = ordy; v.fl = fl;
        v.hold = hold; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ctrl = e_ctrl;
        v.e_data = e_data; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] ctrl, input logic [DW-1:0] data,
                         input logic ordy, input logic fl, input logic hold);
        bus.in_valid  = iv;
        bus.in_ctrl   = ctrl;
        bus.in_data   = data;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.hold_in   = hold;
    endtask

    // Apply inputs, check in_ready before the edge, then outputs just after it.
    task automatic step(input vec_t v, input string tag);
        drive(v.iv, v.ctrl, v.data, v.ordy, v.fl, v.hold);
        #1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(v.e_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v.e_ov));
        chk({tag, ".out_ctrl"}, 64'(bus.out_ctrl), 64'(v.e_ctrl));
        chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(v.e_occ));
        if (v.e_ov) chk({tag, ".out_data"}, 64'(bus.out_data), 64'(v.e_data));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        total  = 0;
        passed = 0;

        //                iv  ctrl     data         ordy fl hold rdy ov e_ctrl   e_data      occ
        vecs[0]  = mk(1, 12'h801, 56'h00A5, 1, 0, 0, 1, 1, 12'h801, 56'h00A5, 2'd1); // fill
        vecs[1]  = mk(0, 12'h000, 56'h0,    1, 0, 0, 1, 0, 12'h000, 56'h0,    2'd0); // drain
        vecs[2]  = mk(1, 12'h0A1, 56'h0A,   0, 0, 0, 1, 1, 12'h0A1, 56'h0A,   2'd1); // A
        vecs[3]  = mk(1, 12'h0B2, 56'h0B,   0, 0, 0, 1, 1, 12'h0A1, 56'h0A,   2'd2); // B to skid
        vecs[4]  = mk(1, 12'h0C3, 56'h0C,   0, 0, 0, 0, 1, 12'h0A1, 56'h0A,   2'd2); // C refused
        vecs[5]  = mk(1, 12'h0C3, 56'h0C,   1, 0, 0, 0, 1, 12'h0B2, 56'h0B,   2'd1); // A out
        vecs[6]  = mk(1, 12'h0C3, 56'h0C,   1, 0, 0, 1, 1, 12'h0C3, 56'h0C,   2'd1); // B out, C in
        vecs[7]  = mk(0, 12'h000, 56'h0,    1, 0, 0, 1, 0, 12'h000, 56'h0,    2'd0); // C out
        vecs[8]  = mk(1, 12'h0D4, 56'h0D,   0, 0, 0, 1, 1, 12'h0D4, 56'h0D,   2'd1);
        vecs[9]  = mk(1, 12'h0E5, 56'h0E,   0, 0, 0, 1, 1, 12'h0D4, 56'h0D,   2'd2);
        vecs[10] = mk(0, 12'h000, 56'h0,    0, 1, 0, 0, 0, 12'h000, 56'h0,    2'd0); // flush FULL
        vecs[11] = mk(0, 12'h000, 56'h0,    1, 0, 0, 1, 0, 12'h000, 56'h0,    2'd0);
        vecs[12] = mk(1, 12'h1F6, 56'h0F,   1, 0, 0, 1, 1, 12'h1F6, 56'h0F,   2'd1);
        vecs[13] = mk(1, 12'h207, 56'h10,   1, 0, 1, 0, 0, 12'h000, 56'h0,    2'd0); // bubble
        vecs[14] = mk(1, 12'h207, 56'h10,   1, 0, 0, 1, 1, 12'h207, 56'h10,   2'd1);
        vecs[15] = mk(0, 12'h000, 56'h0,    1, 0, 0, 1, 0, 12'h000, 56'h0,    2'd0);
        vecs[16] = mk(1, 12'h318, 56'h11,   0, 0, 0, 1, 1, 12'h318, 56'h11,   2'd1);
        vecs[17] = mk(1, 12'h329, 56'h12,   1, 1, 0, 1, 0, 12'h000, 56'h0,    2'd0); // flush ONE+accept
        vecs[18] = mk(0, 12'h000, 56'h0,    1, 0, 0, 1, 0, 12'h000, 56'h0,    2'd0);

        // Reset: outputs quiet while rst is high, in_ready follows hold_in.
        rst = 1'b1;
        drive(0, '0, '0, 0, 0, 0);
        #2;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst.out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        bus.hold_in = 1'b1;
        #1;
        chk("rst.in_ready_hold", 64'(bus.in_ready), 64'd0);
        bus.hold_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) step(vecs[i], $sformatf("vec%0d", i));

        // Streaming: 20 back-to-back beats, one out per cycle, in_ready stays high.
        for (int k = 0; k < 20; k++) begin
            drive(1, CW'(k + 12'h100), DW'(56'h1000 + k), 1, 0, 0);
            #1;
            chk($sformatf("stream%0d.in_ready", k), 64'(bus.in_ready), 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d.out_valid", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("stream%0d.out_data", k), 64'(bus.out_data), 64'(56'h1000 + k));
            chk($sformatf("stream%0d.out_ctrl", k), 64'(bus.out_ctrl), 64'(12'h100 + k));
        end
        drive(0, '0, '0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("stream_end.out_valid", 64'(bus.out_valid), 64'd0);

        // Async reset while FULL: state must clear without a clock edge.
        drive(1, 12'h4A0, 56'h40, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 12'h4B0, 56'h41, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_arst.occupancy", 64'(bus.occupancy), 64'd2);
        drive(0, '0, '0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst.occupancy", 64'(bus.occupancy), 64'd0);
        chk("arst.out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("arst.in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        step(mk(1, 12'h5C0, 56'h50, 1, 0, 0, 1, 1, 12'h5C0, 56'h50, 2'd1), "post_arst");
        step(mk(0, 12'h000, 56'h0,  1, 0, 0, 1, 0, 12'h000, 56'h0,  2'd0), "post_arst_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register for the pipelined core, the successor to the fixed decode/execute latch. It carries a generic control field and a generic data payload from one stage to the next behind a valid/ready handshake, with a two-entry skid buffer. Downstream back-pressure therefore never combinationally reaches upstream. It also supports a synchronous flush for branch mispredicts and a hold input for load-use bubble insertion. One instance is placed at each stage boundary (F/D, D/E, E/M, M/W).

## Interface
Parameters:
- CTRL_W, 12: width of control field (reg_write, mem_write, hlt, etc.)
- DATA_W, 56: width of data payload (operands, immediate, next PC, register addresses)
- ZERO_CTRL, 1: when 1, out_ctrl is forced to all-zero whenever out_valid=0

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream offers a beat
- in_ready  out  1  stage accepts a beat this cycle
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  output holds a valid beat
- out_ready  in  1  downstream consumes the beat this cycle
- out_ctrl  out  CTRL_W  control field of the head beat (or zero, see ZERO_CTRL)
- out_data  out  DATA_W  payload of the head beat
- flush  in  1  synchronous kill of all held beats
- hold_in  in  1  hazard unit blocks acceptance this cycle (bubble insertion)
- occupancy  out  2  number of held beats, 0..2

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each entry has its own valid bit.
- States (occupancy):
  - EMPTY (0): main and skid invalid.
  - ONE (1): main valid, skid invalid.
  - FULL (2): main and skid valid.
- in_ready = ~skid_valid & ~hold_in. It has no path from out_ready.
- Accept condition: in_valid & in_ready. Consume condition: out_valid & out_ready. out_valid = main_valid.
- Transitions, for cycles where flush=0:
  - EMPTY + accept → ONE; main ← in.
  - ONE + accept & ~consume → FULL; skid ← in.
  - ONE + ~accept & consume → EMPTY.
  - ONE + accept & consume → ONE; main ← in.
  - ONE with neither accept nor consume → hold.
  - FULL + consume → ONE; main ← skid. No accept is possible in FULL.
  - FULL + ~consume → hold.
- flush=1 has the highest priority:
  - Next state is EMPTY. Both valid bits are cleared.
  - Any beat accepted or consumed in that cycle is discarded by this stage. The upstream handshake still completes normally.
  - Data registers keep their contents.
- hold_in=1: in_ready=0. Output-side consumption proceeds normally, so the stage drains into a bubble.
- Beats leave in arrival order. No beat is ever duplicated or dropped except by flush.
- Bubble: when out_valid=0 and ZERO_CTRL=1, out_ctrl=0, so downstream sees a NOP (no reg/mem write). out_data is unspecified in a bubble.
- in_valid with in_ready=0 is not an error. Upstream must hold its beat stable until accepted.

## Timing
- Reset values, asserted asynchronously:
  - out_valid=0, occupancy=0
  - main and skid ctrl/data = 0
  - in_ready=~hold_in
- First rising edge after rst deasserts may accept a beat.
- Latency: an accept at edge N gives out_valid=1 with that beat from N+ (1 cycle) when the stage was EMPTY, or when it was ONE with a simultaneous consume.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready falls in the cycle after the edge that fills the skid entry. It rises in the cycle after the edge that drains it.
- Flush: out_valid=0 and occupancy=0 from the edge after flush. in_ready=1 that same cycle if hold_in=0.
- rst mid-operation: all held beats are lost immediately, with no dependence on clk.

## Test plan
- Reset/fill:
  - rst pulse (outputs must be 0 during rst).
  - Then in_valid=1 with data 0x00000000_00A5, ctrl 0x801, out_ready=1.
  - Required: out_valid=1 one cycle later with the same values; occupancy=1.
- Skid fill:
  - Send beats A, B, C while out_ready=0.
  - Required: A and B held; occupancy=2; in_ready=0 after B; C not accepted.
  - Raise out_ready: A, B, C emerge in order on consecutive cycles.
- Streaming: 20 back-to-back beats (incrementing data) with out_ready=1. Required: 20 outputs in order, one per cycle, with in_ready constant at 1.
- Flush while FULL: flush=1 for one cycle. Required: out_valid=0, out_ctrl=0 and occupancy=0 next cycle; the flushed beats never appear.
- Bubble:
  - hold_in=1 for 1 cycle mid-stream, with out_ready=1.
  - Required: in_ready=0 for that cycle; out_valid=0 exactly one cycle later, with out_ctrl=0 (ZERO_CTRL=1).
- Async reset while FULL: rst asserted between clock edges. Required: out_valid and occupancy drop to 0 before the next edge.
